// File: rtl/mod11_encoder.sv
// Bit-serial mod-11 check-digit encoder: emits {payload, c} with the codeword a multiple of 11.
// Optional MOD11_SELF_CHECK_EN adds chk_err, a registered re-check of each finished codeword.
module mod11_encoder #(
  parameter int unsigned DATA_W = 12
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [DATA_W-1:0]   in_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [DATA_W+3:0]   out_code,
  output logic [3:0]          out_check
`ifdef MOD11_SELF_CHECK_EN
  ,
  output logic                chk_err
`endif
);

  localparam int unsigned CODE_W = DATA_W + 4;
  localparam int unsigned CNT_W  = $clog2(CODE_W);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   payload_q, payload_d;
  logic [CODE_W-1:0]   sreg_q, sreg_d;
  logic [3:0]          residue_q, residue_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic                in_ready_d;
  logic                out_valid_d;
  logic [CODE_W-1:0]   out_code_d;
  logic [3:0]          out_check_d;

  logic [4:0]          t;
  logic [3:0]          r_nxt;
  logic [3:0]          check_c;

`ifdef MOD11_SELF_CHECK_EN
  logic                chk_err_d;

  // Independent MSB-first reduction of a full codeword, used only as a sanity re-check.
  function automatic logic [3:0] mod11(input logic [CODE_W-1:0] v);
    logic [4:0] acc;
    logic [3:0] r;
    r = 4'd0;
    for (int i = CODE_W - 1; i >= 0; i--) begin
      acc = {r, 1'b0} + {4'd0, v[i]};
      r   = (acc >= 5'd11) ? 4'(acc - 5'd11) : acc[3:0];
    end
    return r;
  endfunction
`endif

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      payload_q <= '0;
      sreg_q    <= '0;
      residue_q <= 4'd0;
      count_q   <= '0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      out_code  <= '0;
      out_check <= 4'd0;
`ifdef MOD11_SELF_CHECK_EN
      chk_err   <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      payload_q <= payload_d;
      sreg_q    <= sreg_d;
      residue_q <= residue_d;
      count_q   <= count_d;
      in_ready  <= in_ready_d;
      out_valid <= out_valid_d;
      out_code  <= out_code_d;
      out_check <= out_check_d;
`ifdef MOD11_SELF_CHECK_EN
      chk_err   <= chk_err_d;
`endif
    end
  end

  // Next-state, residue update and output load.
  always_comb begin
    state_d     = state_q;
    payload_d   = payload_q;
    sreg_d      = sreg_q;
    residue_d   = residue_q;
    count_d     = count_q;
    out_valid_d = out_valid;
    out_code_d  = out_code;
    out_check_d = out_check;
`ifdef MOD11_SELF_CHECK_EN
    chk_err_d   = chk_err;
`endif

    // Horner step: r <- (2r + b) mod 11, kept in 0..10.
    t       = {residue_q, 1'b0} + {4'd0, sreg_q[CODE_W-1]};
    r_nxt   = (t >= 5'd11) ? 4'(t - 5'd11) : t[3:0];
    check_c = (r_nxt == 4'd0) ? 4'd0 : 4'(4'd11 - r_nxt);

    case (state_q)
      IDLE: begin
        if (in_valid && in_ready) begin
          payload_d = in_data;
          sreg_d    = {in_data, 4'b0000};
          residue_d = 4'd0;
          count_d   = '0;
          state_d   = SHIFT;
        end
      end
      SHIFT: begin
        sreg_d    = {sreg_q[CODE_W-2:0], 1'b0};
        residue_d = r_nxt;
        count_d   = CNT_W'(count_q + 1'b1);
        if (count_q == CNT_W'(CODE_W - 1)) begin
          out_check_d = check_c;
          out_code_d  = {payload_q, check_c};
          out_valid_d = 1'b1;
          state_d     = DONE;
`ifdef MOD11_SELF_CHECK_EN
          chk_err_d   = |mod11({payload_q, check_c});
`endif
        end
      end
      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
`ifdef MOD11_SELF_CHECK_EN
          chk_err_d   = 1'b0;
`endif
        end
      end
      default: state_d = IDLE;
    endcase

    in_ready_d = (state_d == IDLE);
  end

endmodule

// File: tb/tb_mod11_encoder.sv
// Directed self-checking bench for mod11_encoder: known vectors, stall, mid-encode reset, full sweep.
module tb_mod11_encoder;

  localparam int unsigned DATA_W = 12;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [11:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_code;
  logic [3:0]  out_check;
`ifdef MOD11_SELF_CHECK_EN
  logic        chk_err;
`endif

  int checks = 0;
  int errors = 0;

  mod11_encoder #(.DATA_W(DATA_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_code  (out_code),
    .out_check (out_check)
`ifdef MOD11_SELF_CHECK_EN
    ,
    .chk_err   (chk_err)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one payload and hold it until the accepting edge.
  task automatic start(input logic [11:0] p);
    int n = 0;
    while (!in_ready && n < 40) begin
      step();
      n++;
    end
    chk("in_ready_before_accept", 32'(in_ready), 32'd1);
    in_data  = p;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    chk("in_ready_after_accept", 32'(in_ready), 32'd0);
  endtask

  task automatic wait_done();
    int n = 0;
    while (!out_valid && n < 40) begin
      step();
      n++;
    end
    chk("latency", 32'(n), 32'd16);
  endtask

  task automatic pop();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("out_valid_after_pop", 32'(out_valid), 32'd0);
    chk("in_ready_after_pop", 32'(in_ready), 32'd1);
  endtask

  task automatic encode_vec(input logic [11:0] p, input logic [3:0] c, input logic [15:0] code);
    start(p);
    wait_done();
    chk("out_check", 32'(out_check), 32'(c));
    chk("out_code", 32'(out_code), 32'(code));
    chk("out_code_mod11", 32'(out_code) % 11, 32'd0);
`ifdef MOD11_SELF_CHECK_EN
    chk("chk_err", 32'(chk_err), 32'd0);
`endif
    pop();
  endtask

  initial begin
    int          vcount;
    logic [11:0] p;
    logic [3:0]  ec;
    int          rem;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;

    #2;
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_code", 32'(out_code), 32'd0);
    chk("rst_out_check", 32'(out_check), 32'd0);
    step();
    step();
    chk("rst_in_ready_held", 32'(in_ready), 32'd0);
    rst_n = 1'b1;
    step();
    chk("in_ready_after_release", 32'(in_ready), 32'd1);

    encode_vec(12'h000, 4'd0, 16'h0000);
    encode_vec(12'h001, 4'd6, 16'h0016);
    encode_vec(12'h909, 4'd7, 16'h9097);
    encode_vec(12'hFFF, 4'd7, 16'hFFF7);
    encode_vec(12'h00B, 4'd0, 16'h00B0);
    encode_vec(12'h002, 4'd1, 16'h0021);
    encode_vec(12'h003, 4'd7, 16'h0037);
    encode_vec(12'h005, 4'd8, 16'h0058);
    encode_vec(12'h007, 4'd9, 16'h0079);
    encode_vec(12'h009, 4'd10, 16'h009A);

    // Stall with out_ready low; a competing request must be ignored.
    start(12'h909);
    wait_done();
    in_data  = 12'hABC;
    in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("stall_out_valid", 32'(out_valid), 32'd1);
      chk("stall_out_code", 32'(out_code), 32'h9097);
      chk("stall_out_check", 32'(out_check), 32'd7);
      chk("stall_in_ready", 32'(in_ready), 32'd0);
    end
    in_valid = 1'b0;
    pop();

    // Reset five cycles into an encode aborts it.
    start(12'h123);
    for (int i = 0; i < 5; i++) step();
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort_out_valid", 32'(out_valid), 32'd0);
    chk("abort_out_code", 32'(out_code), 32'd0);
    chk("abort_out_check", 32'(out_check), 32'd0);
    chk("abort_in_ready", 32'(in_ready), 32'd0);
    step();
    rst_n  = 1'b1;
    vcount = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (out_valid) vcount++;
    end
    chk("abort_no_output", 32'(vcount), 32'd0);
    chk("abort_in_ready_idle", 32'(in_ready), 32'd1);

    // Every payload: expected check from (16p mod 11), codeword must divide by 11.
    for (int k = 0; k < 4096; k++) begin
      p   = 12'(k);
      rem = (k * 16) % 11;
      ec  = (rem == 0) ? 4'd0 : 4'(11 - rem);
      start(p);
      wait_done();
      chk("sweep_code", 32'(out_code), 32'({p, ec}));
      chk("sweep_div11", 32'(out_code) % 11, 32'd0);
`ifdef MOD11_SELF_CHECK_EN
      chk("sweep_chk_err", 32'(chk_err), 32'd0);
`endif
      pop();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
